program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Sits between the board switches and the F-D-E-W control unit.
- Holds a small buffer of 8-bit instructions loaded by the user, then issues them one at a time on the CPU's instruction input.
- Each issue is timed against the CPU's reported state, so exactly one buffered instruction is consumed per Fetch.
- Supports free-run, single-step and abort; outside an active run it drives NOP (8'h00).

Parameters:
DEPTH, 8, number of instruction slots in the program buffer
AW, 3, pc/slot address width (log2 DEPTH)
IW, 8, instruction width ([7] mode, [6:4] opcode, [3:2] regA, [1:0] regB)

Ports:
clock  in  1  system clock, rising-edge
resetn  in  1  asynchronous active-low reset
load_valid  in  1  write load_instr into next free slot
load_instr  in  IW  instruction to store
load_ready  out  1  buffer accepts a load this cycle
clear  in  1  empty buffer (count=0, pc=0)
run  in  1  start execution from slot 0
step_mode  in  1  1 = pause after each issued instruction
step  in  1  release one instruction while paused
abort  in  1  terminate run immediately
cpu_state  in  2  CPU state: 00 Fetch, 01 Decode, 10 Execute, 11 Writeback
instr_out  out  IW  instruction presented to CPU
pc  out  AW+1  index of next slot to issue
count  out  AW+1  number of loaded slots
seq_state  out  3  000 IDLE, 001 RUN, 010 PAUSE, 011 DRAIN, 100 DONE
busy  out  1  seq_state is RUN, PAUSE or DRAIN
done  out  1  seq_state is DONE

Behaviour:
- Reset (async, resetn=0): seq_state IDLE, pc 0, count 0, instr_out 8'h00, busy 0, done 0, load_ready 1, prev_state register = 2'b11. Buffer contents are not reset.
- All outputs are registered or decoded from registered state. Everything else changes only on rising clock.
- fetch_exit = (prev_state==00 && cpu_state==01). prev_state samples cpu_state every cycle.
- IDLE:
  - load_ready = (count<DEPTH).
  - load_valid && load_ready: buf[count] <= load_instr, count++.
  - load_valid while not ready is ignored.
  - clear: count<=0, pc<=0. Clear wins over load in the same cycle.
  - run with count>0: ->RUN, pc<=0, instr_out<=buf[0] on the same edge.
  - run with count==0: ignored.
- RUN:
  - instr_out holds buf[pc].
  - On fetch_exit: pc++.
  - If the issued slot was the last (pc==count-1): ->DRAIN, instr_out<=00.
  - Else if step_mode: ->PAUSE, instr_out<=00.
  - Else: instr_out<=buf[pc+1], stay in RUN.
  - instr_out is updated one clock after fetch_exit. The CPU spends 3 cycles in D/E/W before the next Fetch, so this is timely.
- PAUSE:
  - instr_out=00; the CPU executes NOPs, and their fetch_exits are not counted.
  - step (level, sampled): ->RUN, instr_out<=buf[pc].
- DRAIN: instr_out=00. When cpu_state==00 (last instruction has completed W): ->DONE.
- DONE:
  - done=1, load_ready=0, instr_out=00.
  - run: ->RUN from pc 0 with the same program.
  - clear: ->IDLE, count 0, pc 0. Run has priority over clear.
- Priority in RUN/PAUSE/DRAIN: abort > fetch_exit > step.
  - abort: ->IDLE, pc<=0, instr_out<=00. count and buffer are retained.
- load_valid, clear and run are ignored while busy.
- A fetch_exit in any non-RUN state has no effect.
- step while not in PAUSE, or with step_mode=0, is ignored. step_mode may change mid-run and is sampled at each fetch_exit.
- Async reset mid-run returns to IDLE with count 0; the program must be reloaded.

Test Plan:
- Load 30,30,10; run; CPU model cycles 00→01→10→11 → instr_out = 30, 30, 10 across the three Fetches, then 00; DRAIN after third fetch_exit; done=1 once cpu_state returns to 00; pc=3, count=3.
- Load 9 words with DEPTH=8 → load_ready=0 after 8th, count=8, 9th word not stored; clear → count=0, load_ready=1.
- step_mode=1, program 30,10 → after first fetch_exit seq_state=010, instr_out=00 for 2 CPU cycles (NOPs not counted, pc stays 1); step → instr_out=10; after its fetch_exit → DRAIN→DONE.
- Abort during RUN at pc=1 → next edge seq_state=000, pc=0, instr_out=00, count unchanged; run → replays from buf[0].
- run with count=0 → stays IDLE, busy=0. Simultaneous abort and fetch_exit → IDLE, pc=0.
- resetn low mid-RUN with no clock edge → seq_state=000, instr_out=00, count=0 immediately.

Source files
------------

// File: rtl/program_sequencer.sv
// Program buffer and issue sequencer feeding one instruction per CPU Fetch.
// Loads in IDLE, then free-runs or single-steps through the buffer until drained.
module program_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int IW    = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          load_valid,
  input  logic [IW-1:0] load_instr,
  output logic          load_ready,
  input  logic          clear,
  input  logic          run,
  input  logic          step_mode,
  input  logic          step,
  input  logic          abort,
  input  logic [1:0]    cpu_state,
  output logic [IW-1:0] instr_out,
  output logic [AW:0]   pc,
  output logic [AW:0]   count,
  output logic [2:0]    seq_state,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } seq_t;

  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] NOP  = {IW{1'b0}};

  seq_t          state;
  seq_t          state_next;
  logic [AW:0]   pc_next;
  logic [AW:0]   count_next;
  logic [IW-1:0] instr_next;
  logic [1:0]    prev_state;
  logic          wr_en;
  logic          fetch_exit;
  logic          last_slot;
  logic [AW:0]   pc_inc;
  logic [IW-1:0] mem [DEPTH];

  assign fetch_exit = (prev_state == 2'b00) && (cpu_state == 2'b01);
  assign pc_inc     = pc + 1'b1;
  assign last_slot  = (pc == (count - 1'b1));
  assign load_ready = (state == S_IDLE) && (count < FULL);
  assign seq_state  = state;
  assign busy       = (state == S_RUN) || (state == S_PAUSE) || (state == S_DRAIN);
  assign done       = (state == S_DONE);

  // Sequencer state and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      pc         <= '0;
      count      <= '0;
      instr_out  <= NOP;
      prev_state <= 2'b11;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      count      <= count_next;
      instr_out  <= instr_next;
      prev_state <= cpu_state;
    end
  end

  // Program storage: deliberately not reset, a reload always precedes use
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[count[AW-1:0]] <= load_instr;
    end
  end

  // Next-state decode; abort outranks fetch_exit, which outranks step
  always_comb begin
    state_next = state;
    pc_next    = pc;
    count_next = count;
    instr_next = instr_out;
    wr_en      = 1'b0;
    case (state)
      S_IDLE: begin
        if (run && (count != '0)) begin
          state_next = S_RUN;
          pc_next    = '0;
          instr_next = mem[0];
        end else if (clear) begin
          count_next = '0;
          pc_next    = '0;
        end else if (load_valid && load_ready) begin
          wr_en      = 1'b1;
          count_next = count + 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next = S_IDLE;
          pc_next    = '0;
          instr_next = NOP;
        end else if (fetch_exit) begin
          pc_next = pc_inc;
          if (last_slot) begin
            state_next = S_DRAIN;
            instr_next = NOP;
          end else if (step_mode) begin
            state_next = S_PAUSE;
            instr_next = NOP;
          end else begin
            instr_next = mem[pc_inc[AW-1:0]];
          end
        end else begin
          state_next = S_RUN;
        end
      end
      S_PAUSE: begin
        if (abort) begin
          state_next = S_IDLE;
          pc_next    = '0;
          instr_next = NOP;
        end else if (step && step_mode) begin
          state_next = S_RUN;
          instr_next = mem[pc[AW-1:0]];
        end else begin
          state_next = S_PAUSE;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_next = S_IDLE;
          pc_next    = '0;
          instr_next = NOP;
        end else if (cpu_state == 2'b00) begin
          state_next = S_DONE;
        end else begin
          state_next = S_DRAIN;
        end
      end
      S_DONE: begin
        if (run) begin
          state_next = S_RUN;
          pc_next    = '0;
          instr_next = mem[0];
        end else if (clear) begin
          state_next = S_IDLE;
          count_next = '0;
          pc_next    = '0;
        end else begin
          state_next = S_DONE;
        end
      end
      default: begin
        state_next = S_IDLE;
        pc_next    = '0;
        instr_next = NOP;
      end
    endcase
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed vector bench for program_sequencer with a hand-stepped F-D-E-W CPU.
module tb_program_sequencer;

  logic       clock;
  logic       resetn;
  logic       load_valid;
  logic [7:0] load_instr;
  logic       load_ready;
  logic       clear;
  logic       run;
  logic       step_mode;
  logic       step;
  logic       abort;
  logic [1:0] cpu_state;
  logic [7:0] instr_out;
  logic [3:0] pc;
  logic [3:0] count;
  logic [2:0] seq_state;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  localparam int I = 0, R = 1, P = 2, DR = 3, DN = 4;

  typedef struct {
    logic       lv;
    logic [7:0] li;
    logic       clr, rn, sm, st, ab;
    logic [1:0] cpu;
    logic [7:0] e_instr;
    logic [3:0] e_pc, e_cnt;
    logic [2:0] e_st;
    logic       e_lr;
  } vec_t;

  vec_t vecs[$];

  program_sequencer dut (
    .clock(clock), .resetn(resetn),
    .load_valid(load_valid), .load_instr(load_instr), .load_ready(load_ready),
    .clear(clear), .run(run), .step_mode(step_mode), .step(step), .abort(abort),
    .cpu_state(cpu_state), .instr_out(instr_out), .pc(pc), .count(count),
    .seq_state(seq_state), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input int lv, input int li, input int clr, input int rn,
                     input int sm, input int st, input int ab, input int cpu,
                     input int ei, input int epc, input int ecnt, input int est,
                     input int elr);
    vec_t v;
    v.lv = 1'(lv); v.li = 8'(li); v.clr = 1'(clr); v.rn = 1'(rn);
    v.sm = 1'(sm); v.st = 1'(st); v.ab = 1'(ab); v.cpu = 2'(cpu);
    v.e_instr = 8'(ei); v.e_pc = 4'(epc); v.e_cnt = 4'(ecnt);
    v.e_st = 3'(est); v.e_lr = 1'(elr);
    vecs.push_back(v);
  endtask

  function automatic logic [21:0] expect_of(input logic [7:0] ei, input logic [3:0] epc,
                                            input logic [3:0] ecnt, input logic [2:0] est,
                                            input logic elr);
    logic eb;
    logic ed;
    eb = (est == 3'd1) || (est == 3'd2) || (est == 3'd3);
    ed = (est == 3'd4);
    return {ei, epc, ecnt, est, elr, eb, ed};
  endfunction

  function automatic logic [21:0] snap();
    return {instr_out, pc, count, seq_state, load_ready, busy, done};
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got instr/pc/cnt/st/lr/busy/done=%h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0; load_valid = 1'b0; load_instr = 8'h00; clear = 1'b0; run = 1'b0;
    step_mode = 1'b0; step = 1'b0; abort = 1'b0; cpu_state = 2'b11;

    // Free run of 30,30,10 with busy-time load/clear/step ignored
    add(1,'h30,0,0,0,0,0,3, 'h00,0,1,I,1);
    add(1,'h30,0,0,0,0,0,3, 'h00,0,2,I,1);
    add(1,'h10,0,0,0,0,0,3, 'h00,0,3,I,1);
    add(0,0,0,1,0,0,0,3, 'h30,0,3,R,0);
    add(0,0,0,0,0,0,0,0, 'h30,0,3,R,0);
    add(0,0,0,0,0,0,0,1, 'h30,1,3,R,0);
    add(1,'hFF,0,0,0,0,0,2, 'h30,1,3,R,0);
    add(0,0,1,0,0,0,0,3, 'h30,1,3,R,0);
    add(0,0,0,0,0,0,0,0, 'h30,1,3,R,0);
    add(0,0,0,0,0,0,0,1, 'h10,2,3,R,0);
    add(0,0,0,0,0,0,0,2, 'h10,2,3,R,0);
    add(0,0,0,0,0,0,0,3, 'h10,2,3,R,0);
    add(0,0,0,0,0,0,0,0, 'h10,2,3,R,0);
    add(0,0,0,0,0,0,0,1, 'h00,3,3,DR,0);
    add(0,0,0,0,0,1,0,2, 'h00,3,3,DR,0);
    add(0,0,0,0,0,0,0,3, 'h00,3,3,DR,0);
    add(0,0,0,0,0,0,0,0, 'h00,3,3,DN,0);
    add(0,0,0,0,0,0,0,1, 'h00,3,3,DN,0);
    // Clear from DONE, overfill by one, clear beats load, run on empty
    add(0,0,1,0,0,0,0,3, 'h00,0,0,I,1);
    for (int k = 1; k <= 9; k++) add(1,k,0,0,0,0,0,3, 'h00,0,(k < 8) ? k : 8,I,(k < 8) ? 1 : 0);
    add(1,'hAA,1,0,0,0,0,3, 'h00,0,0,I,1);
    add(0,0,0,1,0,0,0,3, 'h00,0,0,I,1);
    // Single-step program 30,10
    add(1,'h30,0,0,0,0,0,3, 'h00,0,1,I,1);
    add(1,'h10,0,0,0,0,0,3, 'h00,0,2,I,1);
    add(0,0,0,1,1,0,0,3, 'h30,0,2,R,0);
    add(0,0,0,0,1,0,0,0, 'h30,0,2,R,0);
    add(0,0,0,0,1,0,0,1, 'h00,1,2,P,0);
    add(0,0,0,0,1,0,0,2, 'h00,1,2,P,0);
    add(0,0,0,0,1,0,0,3, 'h00,1,2,P,0);
    add(0,0,0,0,0,1,0,0, 'h00,1,2,P,0);
    add(0,0,0,0,1,0,0,1, 'h00,1,2,P,0);
    add(0,0,0,0,1,0,0,2, 'h00,1,2,P,0);
    add(0,0,0,0,1,1,0,3, 'h10,1,2,R,0);
    add(0,0,0,0,1,0,0,0, 'h10,1,2,R,0);
    add(0,0,0,0,1,0,0,1, 'h00,2,2,DR,0);
    add(0,0,0,0,1,0,0,2, 'h00,2,2,DR,0);
    add(0,0,0,0,1,0,0,3, 'h00,2,2,DR,0);
    add(0,0,0,0,1,0,0,0, 'h00,2,2,DN,0);
    // Rerun from DONE, abort at pc=1, replay, then abort coinciding with fetch_exit
    add(0,0,0,1,0,0,0,3, 'h30,0,2,R,0);
    add(0,0,0,0,0,0,0,0, 'h30,0,2,R,0);
    add(0,0,0,0,0,0,0,1, 'h10,1,2,R,0);
    add(0,0,0,0,0,0,1,2, 'h00,0,2,I,1);
    add(0,0,0,1,0,0,0,3, 'h30,0,2,R,0);
    add(0,0,0,0,0,0,0,0, 'h30,0,2,R,0);
    add(0,0,0,0,0,0,1,1, 'h00,0,2,I,1);
    add(0,0,0,0,0,0,0,2, 'h00,0,2,I,1);

    #2;
    check("reset_state", snap(), expect_of(8'h00, 4'd0, 4'd0, 3'd0, 1'b1));
    #1 resetn = 1'b1;

    foreach (vecs[i]) begin
      load_valid = vecs[i].lv; load_instr = vecs[i].li; clear = vecs[i].clr;
      run = vecs[i].rn; step_mode = vecs[i].sm; step = vecs[i].st;
      abort = vecs[i].ab; cpu_state = vecs[i].cpu;
      tick();
      check($sformatf("row%0d", i), snap(),
            expect_of(vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_cnt, vecs[i].e_st, vecs[i].e_lr));
    end

    // Asynchronous reset in the middle of a run, no clock edge involved
    load_valid = 1'b0; clear = 1'b0; step = 1'b0; abort = 1'b0; step_mode = 1'b0;
    cpu_state = 2'b11; run = 1'b1;
    tick();
    run = 1'b0;
    check("rerun_before_reset", snap(), expect_of(8'h30, 4'd0, 4'd2, 3'd1, 1'b0));
    #2 resetn = 1'b0;
    #1;
    check("async_reset_mid_run", snap(), expect_of(8'h00, 4'd0, 4'd0, 3'd0, 1'b1));
    resetn = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    check("run_after_reset_empty", snap(), expect_of(8'h00, 4'd0, 4'd0, 3'd0, 1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
